// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: scans the ADC channels enabled in chan_mask over SPI.
// Each sample is tagged with its channel and streamed on a valid/ready port.
// The newest sample of every channel is also kept in a shadow bank.
// The ADC is pipelined: the data clocked in during a frame belongs to the
// address sent in the previous frame. The first frame after idle is therefore
// a dummy frame.
module adc_scan_sequencer #(
  parameter int NCH        = 8,
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 12,
  parameter int FRAME_BITS = 16,
  parameter int SCLK_DIV   = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [NCH-1:0]    chan_mask,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso,
  output logic [DATA_W-1:0] sample_data,
  output logic [ADDR_W-1:0] sample_chan,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  output logic              busy,
  input  logic [ADDR_W-1:0] rd_chan,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DIV_W    = $clog2(SCLK_DIV);
  localparam int HALF_W   = $clog2(2 * FRAME_BITS);
  localparam int ADDR_LSB = FRAME_BITS - 2 - ADDR_W;
  localparam logic [DIV_W-1:0]  LAST_DIV  = DIV_W'(SCLK_DIV - 1);
  localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * FRAME_BITS - 1);
  localparam logic [HALF_W-1:0] LAST_LOW  = HALF_W'(2 * FRAME_BITS - 2);

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

  state_t              state, state_next;
  logic [DIV_W-1:0]    div_cnt, div_next;
  logic [HALF_W-1:0]   half_cnt, half_next;
  logic                frame_start, go_idle, sclk_fall, sclk_rise, scan_req;
  logic                pick_found;
  logic [ADDR_W-1:0]   pick_idx, pick_addr;
  logic [ADDR_W-1:0]   next_ptr, cur_addr, prev_addr;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [DATA_W-1:0]   rx_shift;
  logic                first_frame, frame_dummy, done_pulse;
  logic [DATA_W-1:0]   bank [NCH];

  assign scan_req = enable && (|chan_mask);

  // Pick the first enabled channel at or after the pointer, wrapping at NCH-1
  always_comb begin
    pick_addr  = next_ptr;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      pick_idx = ADDR_W'((int'(next_ptr) + k) % NCH);
      if (!pick_found && chan_mask[pick_idx]) begin
        pick_found = 1'b1;
        pick_addr  = pick_idx;
      end
    end
  end

  // Next-state logic: frame timing, plus the sclk edge strobes for the datapath
  always_comb begin
    state_next  = state;
    div_next    = div_cnt;
    half_next   = half_cnt;
    frame_start = 1'b0;
    go_idle     = 1'b0;
    sclk_fall   = 1'b0;
    sclk_rise   = 1'b0;
    unique case (state)
      IDLE: begin
        if (scan_req) begin
          state_next  = CS_SETUP;
          div_next    = '0;
          frame_start = 1'b1;
        end
      end
      CS_SETUP: begin
        if (div_cnt == LAST_DIV) begin
          state_next = SHIFT;
          div_next   = '0;
          half_next  = '0;
          sclk_fall  = 1'b1;
        end else begin
          div_next = div_cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (div_cnt == LAST_DIV) begin
          div_next = '0;
          if (half_cnt == LAST_HALF) begin
            state_next = CS_HOLD;
          end else begin
            half_next = half_cnt + 1'b1;
            sclk_fall = half_cnt[0];
            sclk_rise = !half_cnt[0];
          end
        end else begin
          div_next = div_cnt + 1'b1;
        end
      end
      CS_HOLD: begin
        if (div_cnt == LAST_DIV) begin
          div_next = '0;
          if (scan_req) begin
            state_next  = CS_SETUP;
            frame_start = 1'b1;
          end else begin
            state_next = IDLE;
            go_idle    = 1'b1;
          end
        end else begin
          div_next = div_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; the SPI control pins are registered so they cannot glitch
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      div_cnt  <= '0;
      half_cnt <= '0;
      sclk     <= 1'b1;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      div_cnt  <= div_next;
      half_cnt <= half_next;
      if (sclk_fall) begin
        sclk <= 1'b0;
      end else if (sclk_rise) begin
        sclk <= 1'b1;
      end
      cs_n <= !(state_next == CS_SETUP || state_next == SHIFT);
      busy <= (state_next != IDLE);
    end
  end

  // Shift registers, channel pointers and dummy-frame tracking
  always_ff @(posedge clk) begin
    if (!resetn) begin
      next_ptr    <= '0;
      cur_addr    <= '0;
      prev_addr   <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      mosi        <= 1'b0;
      first_frame <= 1'b1;
      frame_dummy <= 1'b1;
      done_pulse  <= 1'b0;
    end else begin
      done_pulse <= sclk_rise && (half_cnt == LAST_LOW) && !frame_dummy;
      if (frame_start) begin
        cur_addr    <= pick_addr;
        prev_addr   <= cur_addr;
        next_ptr    <= ADDR_W'((int'(pick_addr) + 1) % NCH);
        tx_shift    <= FRAME_BITS'(pick_addr) << ADDR_LSB;
        frame_dummy <= first_frame;
        first_frame <= 1'b0;
      end
      if (go_idle) begin
        first_frame <= 1'b1;
      end
      if (sclk_fall) begin
        mosi     <= tx_shift[FRAME_BITS-1];
        tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
      end
      if (sclk_rise) begin
        rx_shift <= {rx_shift[DATA_W-2:0], miso};
      end
    end
  end

  // Sample delivery: the bank is always written; the stream drops the sample if the consumer stalls
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NCH; i++) begin
        bank[i] <= '0;
      end
      sample_data  <= '0;
      sample_chan  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      rd_data      <= '0;
    end else begin
      overrun <= 1'b0;
      if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (done_pulse) begin
        bank[prev_addr] <= rx_shift;
        if (!sample_valid || sample_ready) begin
          sample_data  <= rx_shift;
          sample_chan  <= prev_addr;
          sample_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (int'(rd_chan) < NCH) begin
        rd_data <= bank[rd_chan];
      end else begin
        rd_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: directed bench for adc_scan_sequencer with a pipelined SPI ADC model.
module tb_adc_scan_sequencer;

  localparam int NCH        = 8;
  localparam int ADDR_W     = 3;
  localparam int DATA_W     = 12;
  localparam int FRAME_BITS = 16;
  localparam int SCLK_DIV   = 4;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              enable = 1'b0;
  logic [NCH-1:0]    chan_mask = '0;
  logic              sclk, cs_n, mosi;
  logic              miso = 1'b0;
  logic [DATA_W-1:0] sample_data;
  logic [ADDR_W-1:0] sample_chan;
  logic              sample_valid;
  logic              sample_ready = 1'b1;
  logic              overrun, busy;
  logic [ADDR_W-1:0] rd_chan = 3'd2;
  logic [DATA_W-1:0] rd_data;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  adc_scan_sequencer #(
    .NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .FRAME_BITS(FRAME_BITS), .SCLK_DIV(SCLK_DIV)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .chan_mask(chan_mask),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .sample_data(sample_data), .sample_chan(sample_chan),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .overrun(overrun), .busy(busy), .rd_chan(rd_chan), .rd_data(rd_data)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp observed events
  always @(posedge clk) cyc <= cyc + 1;

  int fall_cnt = 0, rises_cur = 0, rises_last = 0, sclk_edges = 0, ovr_cnt = 0, busy_cnt = 0;
  int fall_cyc[$];
  int acc_cyc[$];
  logic [14:0] acc_q[$];
  logic prev_cs = 1'b1, prev_sclk = 1'b1;

  // Event monitor sampling the DUT pins on the falling clock edge
  always @(negedge clk) begin
    if (prev_cs && !cs_n) begin
      fall_cnt++;
      fall_cyc.push_back(cyc);
      rises_cur = 0;
    end
    if (!prev_cs && cs_n) rises_last = rises_cur;
    if (prev_sclk !== sclk) begin
      sclk_edges++;
      if (sclk === 1'b1) rises_cur++;
    end
    if (sample_valid && sample_ready) begin
      acc_q.push_back({sample_chan, sample_data});
      acc_cyc.push_back(cyc);
    end
    if (overrun) ovr_cnt++;
    if (busy) busy_cnt++;
    prev_cs = cs_n;
    prev_sclk = sclk;
  end

  // ADC model: converts the address received in the previous frame
  logic [11:0] tbl [NCH] = '{12'h123, 12'h456, 12'hA5C, 12'h789, 12'hABC, 12'hDEF, 12'h135, 12'hF0F};
  logic [15:0] m_word = '0, m_rx = '0;
  logic [2:0]  m_addr = '0;
  int          m_bidx = -1;
  logic [15:0] mosi_q[$];

  // Latch the word to return at frame start
  always @(negedge cs_n) begin
    m_word = {4'hF, tbl[m_addr]};
    m_bidx = 15;
    m_rx = '0;
  end

  // Present the next data bit after each falling sclk
  always @(negedge sclk) begin
    if (!cs_n && m_bidx >= 0) begin
      miso = m_word[m_bidx];
      m_bidx--;
    end
  end

  // Capture mosi on each rising sclk
  always @(posedge sclk) begin
    if (!cs_n) m_rx = {m_rx[14:0], mosi};
  end

  // Decode the address at frame end
  always @(posedge cs_n) begin
    m_addr = m_rx[13:11];
    mosi_q.push_back(m_rx);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic en, input logic [NCH-1:0] mask, input logic rdy);
    enable = en;
    chan_mask = mask;
    sample_ready = rdy;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_cs_fall(input string tag, input int limit);
    int start;
    int n;
    start = fall_cnt;
    n = 0;
    while (fall_cnt == start && n < limit) begin
      tick();
      n++;
    end
    check_output(tag, fall_cnt - start, 1);
  endtask

  // Directed test sequence
  initial begin
    int n, f0, e0, b0, o0;
    int exp_ch[5] = '{0, 1, 7, 0, 1};

    $display("[TB] reset state");
    apply_stimulus(1'b0, '0, 1'b1);
    resetn = 1'b0;
    repeat (3) tick();
    check_output("rst cs_n", cs_n, 1);
    check_output("rst sclk", sclk, 1);
    check_output("rst mosi", mosi, 0);
    check_output("rst busy", busy, 0);
    check_output("rst valid", sample_valid, 0);
    check_output("rst overrun", overrun, 0);
    check_output("rst rd_data", rd_data, 0);
    check_output("rst sample_data", sample_data, 0);
    resetn = 1'b1;
    tick();

    $display("[TB] single channel scan");
    fall_cyc.delete(); acc_q.delete(); acc_cyc.delete(); mosi_q.delete();
    apply_stimulus(1'b1, 8'h04, 1'b1);
    n = 0;
    while (acc_q.size() == 0 && n < 400) begin tick(); n++; end
    check_output("t2 sample count", acc_q.size(), 1);
    check_output("t2 latency", acc_cyc[0] - fall_cyc[0], 265);
    check_output("t2 chan", acc_q[0][14:12], 2);
    check_output("t2 data", acc_q[0][11:0], 12'hA5C);
    repeat (10) tick();
    check_output("t2 cs spacing", fall_cyc[1] - fall_cyc[0], 136);
    check_output("t2 mosi frame1", mosi_q[0], 16'h1000);
    check_output("t2 mosi frame2", mosi_q[1], 16'h1000);
    check_output("t2 rises", rises_last, 16);
    check_output("t2 shadow", rd_data, 12'hA5C);

    $display("[TB] consumer stall");
    wait_cs_fall("t4 frame start", 200);
    repeat (2) tick();
    sample_ready = 1'b0;
    tbl[2] = 12'h3C1;
    o0 = ovr_cnt;
    n = 0;
    while (overrun !== 1'b1 && n < 400) begin tick(); n++; end
    check_output("t4 overrun seen", overrun, 1);
    check_output("t4 held valid", sample_valid, 1);
    check_output("t4 held data", sample_data, 12'hA5C);
    check_output("t4 held chan", sample_chan, 2);
    check_output("t4 rd old", rd_data, 12'hA5C);
    tick();
    check_output("t4 overrun width", overrun, 0);
    check_output("t4 overrun count", ovr_cnt - o0, 1);
    check_output("t4 rd new", rd_data, 12'h3C1);
    check_output("t4 still held", sample_data, 12'hA5C);

    $display("[TB] reset mid-frame");
    wait_cs_fall("t1 frame start", 200);
    repeat (40) tick();
    check_output("t1 pre cs_n", cs_n, 0);
    check_output("t1 pre valid", sample_valid, 1);
    resetn = 1'b0;
    apply_stimulus(1'b0, '0, 1'b1);
    tick();
    check_output("t1 cs_n", cs_n, 1);
    check_output("t1 sclk", sclk, 1);
    check_output("t1 busy", busy, 0);
    check_output("t1 valid", sample_valid, 0);
    check_output("t1 rd_data", rd_data, 0);
    repeat (2) tick();
    resetn = 1'b1;
    tbl[2] = 12'hA5C;
    tick();

    $display("[TB] multi channel scan");
    acc_q.delete();
    apply_stimulus(1'b1, 8'h83, 1'b1);
    n = 0;
    while (acc_q.size() < 5 && n < 1000) begin tick(); n++; end
    check_output("t3 sample count", acc_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check_output($sformatf("t3 chan %0d", i), acc_q[i][14:12], exp_ch[i]);
      check_output($sformatf("t3 data %0d", i), acc_q[i][11:0], tbl[exp_ch[i]]);
    end

    $display("[TB] enable drop mid-frame");
    wait_cs_fall("t5 frame start", 200);
    n = 0;
    while (rises_cur < 5 && n < 100) begin tick(); n++; end
    check_output("t5 at rise 5", rises_cur, 5);
    enable = 1'b0;
    n = 0;
    while (cs_n !== 1'b1 && n < 200) begin tick(); n++; end
    repeat (SCLK_DIV + 2) tick();
    check_output("t5 rises", rises_last, 16);
    check_output("t5 sample count", acc_q.size(), 6);
    check_output("t5 chan", acc_q[5][14:12], 7);
    check_output("t5 data", acc_q[5][11:0], 12'hF0F);
    check_output("t5 cs_n", cs_n, 1);
    check_output("t5 busy", busy, 0);
    f0 = fall_cnt;
    repeat (200) tick();
    check_output("t5 stays idle", fall_cnt, f0);

    $display("[TB] empty mask");
    apply_stimulus(1'b1, 8'h00, 1'b1);
    f0 = fall_cnt; e0 = sclk_edges; b0 = busy_cnt;
    repeat (1000) tick();
    check_output("t6 no frames", fall_cnt, f0);
    check_output("t6 no sclk", sclk_edges, e0);
    check_output("t6 never busy", busy_cnt, b0);
    check_output("t6 cs_n", cs_n, 1);
    chan_mask = 8'h01;
    tick();
    check_output("t6 start busy", busy, 1);
    check_output("t6 start cs_n", cs_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
